smg_scan: RTL

//  Time-multiplexed driver for the 4-digit, 8-segment display behind the SoC smg[11:0] pins.

---
 rtl/smg_scan_pkg.sv | 25 ++
 rtl/smg_scan_hex_decode.sv | 35 +++
 rtl/smg_scan.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/smg_scan_pkg.sv
// Shared definitions for the 4-digit seven-segment scanner.
//  - state_t      : per-slot scan state (dead time / digit lit)
//  - SMG_OFF      : all anodes and segments off (active-low pins)
//  - HEX7_*       : a few active-high segment patterns, {g,f,e,d,c,b,a}
//  - digit_anode  : active-low one-hot anode pattern for a digit index
package smg_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [11:0] SMG_OFF = 12'hFFF;

    localparam logic [6:0] HEX7_0 = 7'h3F;
    localparam logic [6:0] HEX7_3 = 7'h4F;
    localparam logic [6:0] HEX7_4 = 7'h66;
    localparam logic [6:0] HEX7_5 = 7'h6D;

    // Active-low anode pattern that lights only digit idx.
    function automatic logic [3:0] digit_anode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/smg_scan_hex_decode.sv
// Hex nibble to seven-segment decoder, purely combinational.
//  digit : 4-bit hex value
//  seg7  : active-high segments {g,f,e,d,c,b,a}
module smg_hex_decode
    import smg_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg7
);

    // Standard 0-F segment table.
    always_comb begin
        seg7 = 7'h00;
        case (digit)
            4'h0:    seg7 = HEX7_0;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = HEX7_3;
            4'h4:    seg7 = HEX7_4;
            4'h5:    seg7 = HEX7_5;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            4'hF:    seg7 = 7'h71;
            default: seg7 = 7'h00;
        endcase
    end

endmodule

// File: rtl/smg_scan.sv
// Time-multiplexed driver for a 4-digit, 8-segment display.
// Each digit slot is BLANK_CYC dead-time cycles followed by SCAN_DIV lit
// cycles. New values are written into a pending register and only copied to
// the displayed (shadow) register at a frame boundary, so a frame never tears.
//  clk, reset   : clock, asynchronous active-low reset
//  en           : scan enable (0 = dark, scan parked at digit0 BLANK)
//  lzb          : leading-zero blanking enable
//  wr_en        : strobe capturing wr_data / wr_mask / wr_dp
//  smg          : {an[3:0], seg[7:0]} active-low, registered
//  upd_pending  : a write is waiting for the next frame boundary
//  frame_done   : pulse on the last lit cycle of digit3
module smg_scan
    import smg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        lzb,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_mask,
    input  logic [3:0]  wr_dp,
    output logic [11:0] smg,
    output logic        upd_pending,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] LAST_SHOW  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_r, state_n;
    logic [1:0]       idx_r, idx_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;

    logic [15:0] pend_value_r, shadow_value_r;
    logic [3:0]  pend_mask_r, shadow_mask_r;
    logic [3:0]  pend_dp_r, shadow_dp_r;
    logic        upd_pending_r;
    logic        frame_done_r;
    logic [11:0] smg_r, smg_n;

    logic        commit_s;
    logic [3:0]  digit_nib_s;
    logic [6:0]  seg7_s;
    logic [3:0]  lzb_blank_s;
    logic        digit_on_s;
    logic [3:0]  an_s;

    smg_hex_decode u_hex_decode (
        .digit (digit_nib_s),
        .seg7  (seg7_s)
    );

    // Slot sequencing: next state, digit index and slot counter.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        cnt_n   = cnt_r + CNT_ONE;
        if (!en) begin
            state_n = S_BLANK;
            idx_n   = 2'd0;
            cnt_n   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_BLANK: begin
                    if (cnt_r == LAST_BLANK) begin
                        state_n = S_SHOW;
                        cnt_n   = {CNT_W{1'b0}};
                    end else begin
                        state_n = S_BLANK;
                    end
                end
                S_SHOW: begin
                    if (cnt_r == LAST_SHOW) begin
                        idx_n   = idx_r + 2'd1;
                        cnt_n   = {CNT_W{1'b0}};
                        state_n = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;
                    end else begin
                        state_n = S_SHOW;
                    end
                end
                default: begin
                    state_n = S_BLANK;
                    idx_n   = 2'd0;
                    cnt_n   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Commit at the frame boundary, or whenever the scan is parked.
    // frame_done_r is high exactly while the state is the last lit cycle of digit3.
    assign commit_s = (upd_pending_r || wr_en) && (frame_done_r || !en);

    // Leading-zero blanking from the displayed value; digit0 is never blanked.
    always_comb begin
        lzb_blank_s    = 4'b0000;
        lzb_blank_s[1] = lzb && (shadow_value_r[15:4]  == 12'h000);
        lzb_blank_s[2] = lzb && (shadow_value_r[15:8]  == 8'h00);
        lzb_blank_s[3] = lzb && (shadow_value_r[15:12] == 4'h0);
    end

    // Select the current digit's nibble and build the next display word.
    always_comb begin
        digit_nib_s = 4'h0;
        case (idx_r)
            2'd0:    digit_nib_s = shadow_value_r[3:0];
            2'd1:    digit_nib_s = shadow_value_r[7:4];
            2'd2:    digit_nib_s = shadow_value_r[11:8];
            2'd3:    digit_nib_s = shadow_value_r[15:12];
            default: digit_nib_s = 4'h0;
        endcase
        digit_on_s = shadow_mask_r[idx_r] && !lzb_blank_s[idx_r];
        if (digit_on_s) begin
            an_s = digit_anode(idx_r);
        end else begin
            an_s = 4'hF;
        end
        if (en && (state_r == S_SHOW)) begin
            smg_n = {an_s, ~{shadow_dp_r[idx_r], seg7_s}};
        end else begin
            smg_n = SMG_OFF;
        end
    end

    // Scan state, counter, registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_BLANK;
            idx_r        <= 2'd0;
            cnt_r        <= {CNT_W{1'b0}};
            smg_r        <= SMG_OFF;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            idx_r        <= idx_n;
            cnt_r        <= cnt_n;
            smg_r        <= smg_n;
            frame_done_r <= (state_n == S_SHOW) && (idx_n == 2'd3) && (cnt_n == LAST_SHOW);
        end
    end

    // Pending/shadow registers; a write coinciding with commit bypasses pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_value_r   <= 16'h0000;
            pend_mask_r    <= 4'h0;
            pend_dp_r      <= 4'h0;
            shadow_value_r <= 16'h0000;
            shadow_mask_r  <= 4'h0;
            shadow_dp_r    <= 4'h0;
            upd_pending_r  <= 1'b0;
        end else begin
            if (wr_en) begin
                pend_value_r <= wr_data;
                pend_mask_r  <= wr_mask;
                pend_dp_r    <= wr_dp;
            end else begin
                pend_value_r <= pend_value_r;
                pend_mask_r  <= pend_mask_r;
                pend_dp_r    <= pend_dp_r;
            end
            if (commit_s) begin
                shadow_value_r <= wr_en ? wr_data : pend_value_r;
                shadow_mask_r  <= wr_en ? wr_mask : pend_mask_r;
                shadow_dp_r    <= wr_en ? wr_dp   : pend_dp_r;
                upd_pending_r  <= 1'b0;
            end else begin
                upd_pending_r  <= upd_pending_r || wr_en;
            end
        end
    end

    assign smg         = smg_r;
    assign upd_pending = upd_pending_r;
    assign frame_done  = frame_done_r;

endmodule
